fp_mul_share_arb: RTL and testbench
===================================

Name: fp_mul_share_arb

Overview:
- Shares one registered 16-bit bfloat-style FP multiplier (1/8/7 format, 2-cycle registered latency) among NREQ independent requesters.
- Round-robin arbitration; at most one issue per cycle; each requester may have only one operation outstanding.
- Results are routed back through per-requester one-entry result buffers with valid/ready handshake.
- Sits between engine-level clients and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width
- MUL_LAT, 2, clock edges from multiplier operand sampling to capture of its result (operands sampled at edge k, result captured by this block at edge k+MUL_LAT)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_a  input  NREQ*W  operand A, requester i at [i*W +: W]
- req_b  input  NREQ*W  operand B, same packing
- rsp_valid  output  NREQ  per-requester result valid
- rsp_ready  input  NREQ  per-requester result consumed
- rsp_y  output  NREQ*W  result, requester i at [i*W +: W]
- mul_a  output  W  operand A to multiplier
- mul_b  output  W  operand B to multiplier
- mul_y  input  W  multiplier result
- busy  output  1  any operation in flight or any rsp_valid set

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_y=0, rr_ptr=0, in-flight pipeline valid bits cleared, owner[] cleared.
  - Operations in flight at reset are discarded; their mul_y values are never captured.
- Eligibility: requester i is eligible when req_valid[i] & ~owner[i].
  - owner[i] is set at acceptance.
  - owner[i] is cleared when rsp_valid[i]&rsp_ready[i] is seen at an edge.
- Grant (combinational):
  - Scan eligible requesters starting at rr_ptr, wrapping modulo NREQ; the first eligible one is granted.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - No eligible requester: req_ready=0.
  - req_ready never depends on rsp_ready.
- Acceptance: an edge with req_valid[i]&req_ready[i].
  - At that edge: owner[i]<=1; rr_ptr<=(i+1) mod NREQ; in-flight stage 0 <= {valid=1, id=i}.
  - rr_ptr is unchanged on cycles without acceptance.
- Operand drive:
  - mul_a/mul_b = granted requester's req_a/req_b (combinational), and 0 when there is no grant.
  - The multiplier samples them at the same edge as acceptance.
- In-flight tracking: shift register of depth MUL_LAT holding {valid,id}, advancing every cycle.
- Capture: when the last stage is valid at an edge, rsp_y[id]<=mul_y and rsp_valid[id]<=1.
- Latency: acceptance at edge k -> rsp_valid[i] high after edge k+MUL_LAT (2 edges by default).
- Back-to-back issue: a new acceptance is possible every cycle from different requesters; throughput is 1 op/cycle.
- Response handshake:
  - rsp_valid[i] and rsp_y[i] hold stable until rsp_valid[i]&rsp_ready[i].
  - rsp_valid[i] clears at that edge; rsp_y[i] retains its last value.
- Re-issue: the same requester may be granted in the cycle after its response handshake.
  - It is not granted in the same cycle as the handshake, because owner is still set during that cycle.
- Simultaneous events:
  - A capture and a response pop can never hit the same index in one cycle, because only one op per requester is outstanding.
  - A capture for i and a pop for j≠i in the same cycle are independent.
- Arithmetic: no arithmetic inside this block. mul_y is passed through unmodified, including any exponent wrap produced by the multiplier.
- busy = |in-flight valid | |rsp_valid.
- Reset mid-operation: the block reaches the reset state immediately. No rsp_valid may appear from pre-reset issues, even though the multiplier itself has no reset.

Test Plan:
- Single op: req 0 sends a=0x3F80, b=0x4000 at edge k -> req_ready[0]=1 in that cycle, rsp_valid[0]=1 after edge k+2, rsp_y[0]=0x4000, busy=1 from k to pop.
- All four valid with rsp_ready held 1:
  - Operands: a=0x3FC0,b=0x3FC0 / a=0xC000,b=0x4040 / a=0x3F80,b=0x3F80 / a=0x4000,b=0x4000.
  - Grants must be 0,1,2,3 on consecutive edges.
  - Results 0x4010, 0xC0C0, 0x3F80, 0x4080 must appear on consecutive cycles.
- Fairness: req 0 and req 2 continuously valid with immediate pop -> grants alternate 0,2,0,2; req 0 is never granted twice in a row while req 2 waits.
- Backpressure: req 1 result held (rsp_ready[1]=0) for 10 cycles while req_valid[1]=1.
  - req_ready[1] must stay 0 and rsp_y[1] must stay stable.
  - After the pop, req 1 is granted the next cycle.
- Reset mid-flight: assert rst_n=0 one cycle after accepting req 3 -> rsp_valid stays 0 after release, rr_ptr=0, so the next grant with all requesters valid goes to req 0.
- Idle: no req_valid -> req_ready=0, mul_a=mul_b=0, busy=0, rr_ptr unchanged.

Source files
------------

// File: rtl/fp_mul_share_arb_if.sv
// Client/multiplier bus for the shared bfloat multiplier arbiter.
// Holds the per-requester request/response handshakes and the multiplier port.
interface fp_mul_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*W-1:0] rsp_y;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_y;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_y,
        output req_ready, rsp_valid, rsp_y, mul_a, mul_b, busy
    );

    // Clients plus multiplier side
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_y,
        input  req_ready, rsp_valid, rsp_y, mul_a, mul_b, busy
    );
endinterface

// File: rtl/fp_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined bfloat multiplier among NREQ clients.
// Each client has at most one op outstanding; results land in a one-entry
// per-client buffer with a valid/ready handshake.
module fp_mul_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned MUL_LAT = 2
) (
    input logic               clk,
    input logic               rst_n,
    fp_mul_share_arb_if.slave bus
);
    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*W-1:0]  rsp_y_q, rsp_y_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT-1:0] pipe_vld_q;
    logic [IdW-1:0]     pipe_id_q [MUL_LAT];

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pop;
    logic            grant_vld;
    logic [IdW-1:0]  grant_id;
    logic            cap_vld;
    logic [IdW-1:0]  cap_id;

    // Owned requesters are masked until their result has been popped
    assign eligible = bus.req_valid & ~owner_q;
    assign pop      = rsp_valid_q & bus.rsp_ready;
    assign cap_vld  = pipe_vld_q[MUL_LAT-1];
    assign cap_id   = pipe_id_q[MUL_LAT-1];

    // Round-robin scan starting at rr_ptr; first eligible requester wins
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (32'(rr_ptr_q) + off) % NREQ;
            if (!grant_vld && eligible[IdW'(idx)]) begin
                grant_vld = 1'b1;
                grant_id  = IdW'(idx);
            end
        end
    end

    // Grant, operand mux and pointer advance; the grant is the acceptance
    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        rr_ptr_d      = rr_ptr_q;
        if (grant_vld) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.mul_a = bus.req_a[32'(grant_id)*W +: W];
            bus.mul_b = bus.req_b[32'(grant_id)*W +: W];
            rr_ptr_d  = IdW'((32'(grant_id) + 1) % NREQ);
        end
    end

    // Ownership and result buffers; capture and pop never hit the same index
    always_comb begin
        owner_d     = owner_q & ~pop;
        rsp_valid_d = rsp_valid_q & ~pop;
        rsp_y_d     = rsp_y_q;
        if (grant_vld) begin
            owner_d[grant_id] = 1'b1;
        end
        if (cap_vld) begin
            rsp_valid_d[cap_id]             = 1'b1;
            rsp_y_d[32'(cap_id)*W +: W]     = bus.mul_y;
        end
    end

    // Arbiter and result-buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // In-flight tracker mirrors the multiplier pipeline; reset drops pending ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= grant_vld;
            pipe_id_q[0]  <= grant_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.busy      = (|pipe_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_mul_share_arb.sv
// Directed bench for fp_mul_share_arb with a 2-stage bfloat multiplier model.
module tb_fp_mul_share_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp_mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    fp_mul_share_arb #(.NREQ(NREQ), .W(W), .MUL_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Truncating bfloat multiply, normal operands only, no reset on the pipe
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [9:0]  e;
        logic [6:0]  m;
        p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = {2'b00, a[14:7]} + {2'b00, b[14:7]} - 10'd127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 10'd1;
        end else begin
            m = p[13:7];
        end
        return {a[15] ^ b[15], e[7:0], m};
    endfunction

    logic [W-1:0] mul_s1, mul_s2;
    always @(posedge clk) begin
        mul_s1 <= bf16_mul(bus.mul_a, bus.mul_b);
        mul_s2 <= mul_s1;
    end
    assign bus.mul_y = mul_s2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*W +: W]   = a;
        bus.req_b[i*W +: W]   = b;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [15:0] y_of(input int i);
        return bus.rsp_y[i*W +: W];
    endfunction

    logic [15:0] t2_a [4] = '{16'h3FC0, 16'hC000, 16'h3F80, 16'h4000};
    logic [15:0] t2_b [4] = '{16'h3FC0, 16'h4040, 16'h3F80, 16'h4000};
    logic [15:0] t2_y [4] = '{16'h4010, 16'hC0C0, 16'h3F80, 16'h4080};
    logic [3:0]  exp4;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_y", bus.rsp_y, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 0);

        // Single op on requester 0, exact 2-edge latency
        @(posedge clk); #1;
        set_req(0, 16'h3F80, 16'h4000);
        @(negedge clk);
        check("t1_ready", bus.req_ready, 4'b0001);
        check("t1_mul_a", bus.mul_a, 16'h3F80);
        check("t1_mul_b", bus.mul_b, 16'h4000);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_k", bus.busy, 1);
        check("t1_vld_k", bus.rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_vld_k1", bus.rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_vld_k2", bus.rsp_valid, 4'b0001);
        check("t1_y", y_of(0), 16'h4000);
        check("t1_busy_k2", bus.busy, 1);
        @(posedge clk); #1;
        bus.rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("t1_vld_pop", bus.rsp_valid, 0);
        check("t1_busy_pop", bus.busy, 0);
        check("t1_y_hold", y_of(0), 16'h4000);

        // All four requesters, back-to-back grants and results
        do_reset();
        bus.rsp_ready = '1;
        for (int i = 0; i < 4; i++) set_req(i, t2_a[i], t2_b[i]);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 4) begin
                exp4 = 4'b0001 << c;
                check($sformatf("t2_grant%0d", c), bus.req_ready, exp4);
            end
            if (c >= 3) begin
                exp4 = 4'b0001 << (c - 3);
                check($sformatf("t2_rsp_vld%0d", c - 3), bus.rsp_valid, exp4);
                check($sformatf("t2_rsp_y%0d", c - 3), y_of(c - 3), t2_y[c-3]);
            end
            @(posedge clk); #1;
            if (c < 4) bus.req_valid[c] = 1'b0;
        end

        // Fairness between requesters 0 and 2, immediate pop
        do_reset();
        bus.rsp_ready = '1;
        set_req(0, 16'h4000, 16'h3F80);
        set_req(2, 16'h4040, 16'h4000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp4 = (c % 4 == 0) ? 4'b0001 : (c % 4 == 1) ? 4'b0100 : 4'b0000;
            check($sformatf("t3_grant%0d", c), bus.req_ready, exp4);
            if (c % 4 == 3) begin
                check($sformatf("t3_vld%0d", c), bus.rsp_valid, 4'b0001);
                check($sformatf("t3_y0_%0d", c), y_of(0), 16'h4000);
            end
            if (c % 4 == 0 && c > 0) begin
                check($sformatf("t3_vld%0d", c), bus.rsp_valid, 4'b0100);
                check($sformatf("t3_y2_%0d", c), y_of(2), 16'h40C0);
            end
            @(posedge clk); #1;
        end

        // Backpressure on requester 1
        do_reset();
        bus.rsp_ready = 4'b1101;
        set_req(1, 16'h3FC0, 16'h4000);
        @(negedge clk);
        check("t4_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        set_req(1, 16'h4000, 16'h4000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_vld", bus.rsp_valid, 4'b0010);
        check("t4_y", y_of(1), 16'h4040);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("t4_hold_ready%0d", c), bus.req_ready, 0);
            check($sformatf("t4_hold_y%0d", c), {bus.rsp_valid, y_of(1)}, {4'b0010, 16'h4040});
        end
        @(posedge clk); #1;
        bus.rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("t4_no_grant_in_pop", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.rsp_ready[1] = 1'b0;
        @(negedge clk);
        check("t4_regrant", bus.req_ready, 4'b0010);
        check("t4_vld_popped", bus.rsp_valid, 0);
        check("t4_y_retained", y_of(1), 16'h4040);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_vld2", bus.rsp_valid, 4'b0010);
        check("t4_y2", y_of(1), 16'h4080);

        // Reset while requester 3's op is in flight
        do_reset();
        set_req(3, 16'h4040, 16'h4040);
        @(negedge clk);
        check("t5_grant3", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_in_rst_vld", bus.rsp_valid, 0);
        check("t5_in_rst_busy", bus.busy, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t5_post_vld%0d", c), bus.rsp_valid, 0);
            check($sformatf("t5_post_busy%0d", c), bus.busy, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) set_req(i, t2_a[i], t2_b[i]);
        @(negedge clk);
        check("t5_grant0", bus.req_ready, 4'b0001);

        // Idle: no requests, pointer must hold at 1
        bus.rsp_ready = '1;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t6_ready%0d", c), bus.req_ready, 0);
            check($sformatf("t6_mul%0d", c), {bus.mul_a, bus.mul_b}, 0);
            check($sformatf("t6_busy%0d", c), bus.busy, 0);
            @(posedge clk); #1;
        end
        bus.req_valid = '1;
        @(negedge clk);
        check("t6_rr_held", bus.req_ready, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
